datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- pcen  input  1  PC load enable
- irwrite  input  1  instruction register load enable
- regwrite  input  1  register file write enable
- alusrca  input  1  ALU A select: 0 = PC, 1 = A register
- iord  input  1  address select: 0 = PC, 1 = ALUOut
- memtoreg  input  1  write-data select: 0 = ALUOut, 1 = Data register
- regdst  input  1  write-address select: 0 = instr[20:16], 1 = instr[15:11]
- alusrcb  input  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  input  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = ALUOut
- alucontrol  input  3  ALU operation code
- readdata  input  32  memory read data
- adr  output  32  memory address
- writedata  output  32  memory write data
- op  output  6  instr[31:26], to controller
- funct  output  6  instr[5:0], to controller
- zero  output  1  ALUResult == 0, to controller

Function
REQ-003 The block SHALL contain 32-bit registers PC, Instr, Data, A, B, ALUOut, and a 32x32 register file.
REQ-004 PC SHALL load the next-PC mux on a clk rise when pcen=1, and otherwise hold.
REQ-005 Instr SHALL load readdata on a clk rise when irwrite=1, and otherwise hold.
REQ-006 Data, A, B and ALUOut SHALL load on every clk rise with no enable:
- Data <= readdata
- A <= RF[instr[25:21]]
- B <= RF[instr[20:16]]
- ALUOut <= ALUResult
REQ-007 Register file reads SHALL be combinational, and register 0 SHALL always read 0.
REQ-008 The register file SHALL write on a clk rise when regwrite=1, to the regdst-selected address, with the memtoreg-selected data.
REQ-009 Writes to address 0 SHALL be discarded.
REQ-010 When the register file is written and read at the same address in the same cycle, A and B SHALL capture the pre-write value.
REQ-011 adr SHALL equal iord ? ALUOut : PC, combinationally.
REQ-012 writedata SHALL equal B.
REQ-013 SignImm SHALL be instr[15:0] sign-extended to 32 bits; SignImm<<2 SHALL be SignImm shifted left 2, with the upper bits discarded.
REQ-014 The jump target SHALL be {PC[31:28], instr[25:0], 2'b00}, using the current PC value.
REQ-015 The ALU SHALL implement these alucontrol codes; all arithmetic is 32-bit modulo, with no overflow flag:
- 010 add
- 110 subtract
- 000 AND
- 001 OR
- 111 set-less-than, signed, result 0 or 1
- 100 A AND ~B
- 101 A OR ~B
- 011 result 0
REQ-016 zero SHALL be combinational from the current ALUResult.
REQ-017 op and funct SHALL be driven combinationally from Instr.
REQ-018 All register transfers SHALL take exactly one cycle; the block SHALL have no internal sequencing beyond the control inputs.

Reset
REQ-019 While reset=1, PC, Instr, Data, A, B, ALUOut and all 32 register-file entries SHALL clear to 0 immediately, regardless of clk.
REQ-020 During reset, adr SHALL be 0, op SHALL be 0 and funct SHALL be 0.
REQ-021 An assertion of reset mid-instruction SHALL abandon that instruction; after deassertion, execution SHALL restart with a fetch from address 0.
REQ-022 Control inputs SHALL be ignored while reset=1.

Verification
REQ-023 Reset: assert reset, then drive pcen=1 -> adr=0x00000000, op=000000, zero=1 (ALU 0+0 with alusrcb=00), and PC stays 0.
REQ-024 Fetch: readdata=0x20020005, irwrite=1, pcen=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, one edge -> op=001000, PC=0x4, adr=0x4.
REQ-025 addi writeback: after REQ-024, run decode, then execute (alusrca=1, alusrcb=10, add), then write (regwrite=1, regdst=0, memtoreg=0) -> RF[2]=5.
REQ-026 beq branch: A=B=7, alusrca=1, alusrcb=00, alucontrol=110 -> zero=1. Then pcsrc=01 with ALUOut=0x20 and pcen=1 -> PC=0x20.
REQ-027 Jump: PC=0x10000004, instr=0x08000010, pcsrc=10, pcen=1 -> PC=0x10000040.
REQ-028 Edge cases:
- regwrite=1 to address 0 with data 0xFFFFFFFF -> RF[0] still reads 0.
- slt with A=0x80000000, B=1 -> ALUResult=1.
- Reset asserted between clk edges -> PC=0 before the next edge.

Source files
------------

// File: rtl/datapath.sv
// Multicycle MIPS-style datapath: PC, instruction/data latches, A/B/ALUOut
// registers, 32x32 register file and ALU, all steered by an external controller.
module datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic [31:0] readdata,
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, data_q, a_q, b_q, aluout_q;
    logic [31:0] rf_q [32];

    logic [4:0]  wa_s;
    logic [31:0] wd_s, rd1_s, rd2_s;
    logic [31:0] signimm_s, srca_s, srcb_s, alu_result_s;

    assign signimm_s = {{16{instr_q[15]}}, instr_q[15:0]};
    assign wa_s      = regdst ? instr_q[15:11] : instr_q[20:16];
    assign wd_s      = memtoreg ? data_q : aluout_q;
    assign rd1_s     = (instr_q[25:21] == 5'd0) ? 32'd0 : rf_q[instr_q[25:21]];
    assign rd2_s     = (instr_q[20:16] == 5'd0) ? 32'd0 : rf_q[instr_q[20:16]];
    assign srca_s    = alusrca ? a_q : pc_q;

    // ALU B operand select
    always_comb begin
        srcb_s = b_q;
        case (alusrcb)
            2'b00:   srcb_s = b_q;
            2'b01:   srcb_s = 32'd4;
            2'b10:   srcb_s = signimm_s;
            2'b11:   srcb_s = {signimm_s[29:0], 2'b00};
            default: srcb_s = b_q;
        endcase
    end

    // ALU: 32-bit modulo arithmetic, signed set-less-than
    always_comb begin
        alu_result_s = 32'd0;
        case (alucontrol)
            3'b010:  alu_result_s = srca_s + srcb_s;
            3'b110:  alu_result_s = srca_s - srcb_s;
            3'b000:  alu_result_s = srca_s & srcb_s;
            3'b001:  alu_result_s = srca_s | srcb_s;
            3'b111:  alu_result_s = ($signed(srca_s) < $signed(srcb_s)) ? 32'd1 : 32'd0;
            3'b100:  alu_result_s = srca_s & ~srcb_s;
            3'b101:  alu_result_s = srca_s | ~srcb_s;
            3'b011:  alu_result_s = 32'd0;
            default: alu_result_s = 32'd0;
        endcase
    end

    // Next-PC select; jump target uses the current PC's top nibble
    always_comb begin
        pc_d = aluout_q;
        case (pcsrc)
            2'b00:   pc_d = alu_result_s;
            2'b01:   pc_d = aluout_q;
            2'b10:   pc_d = {pc_q[31:28], instr_q[25:0], 2'b00};
            2'b11:   pc_d = aluout_q;
            default: pc_d = aluout_q;
        endcase
    end

    // Architectural and pipeline-style holding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 32'd0;
            instr_q  <= 32'd0;
            data_q   <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            if (pcen) begin
                pc_q <= pc_d;
            end
            if (irwrite) begin
                instr_q <= readdata;
            end
            data_q   <= readdata;
            a_q      <= rd1_s;
            b_q      <= rd2_s;
            aluout_q <= alu_result_s;
        end
    end

    // Register file write port; A/B above see the pre-write contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (regwrite && (wa_s != 5'd0)) begin
            rf_q[wa_s] <= wd_s;
        end
    end

    assign adr       = iord ? aluout_q : pc_q;
    assign writedata = b_q;
    assign op        = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign zero      = (alu_result_s == 32'd0);

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of the datapath against a register-transfer
// reference model written from the block's behavioural rules.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] readdata, adr, writedata;
    logic [5:0]  op, funct;
    logic        zero;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_alo;
    logic [31:0] m_rf [32];

    datapath dut (
        .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
        .adr(adr), .writedata(writedata), .op(op), .funct(funct), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] c);
        case (c)
            3'd2:    return x + y;
            3'd6:    return x - y;
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd7:    return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            3'd4:    return x & ~y;
            3'd5:    return x | ~y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] imm, x, y;
        imm = 32'($signed(m_ir[15:0]));
        x = alusrca ? m_a : m_pc;
        case (alusrcb)
            2'd0:    y = m_b;
            2'd1:    y = 32'd4;
            2'd2:    y = imm;
            default: y = imm * 32'd4;
        endcase
        return alu_ref(x, y, alucontrol);
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_rf[idx];
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_ir = 32'd0; m_data = 32'd0;
        m_a = 32'd0; m_b = 32'd0; m_alo = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    task automatic model_edge();
        logic [31:0] res, npc, wd, ra, rb;
        logic [4:0]  wa;
        if (reset) begin
            model_reset();
        end else begin
            res = ref_result();
            case (pcsrc)
                2'd0:    npc = res;
                2'd2:    npc = {m_pc[31:28], 28'(m_ir[25:0] * 4)};
                default: npc = m_alo;
            endcase
            wa = regdst ? m_ir[15:11] : m_ir[20:16];
            wd = memtoreg ? m_data : m_alo;
            ra = rf_read(m_ir[25:21]);
            rb = rf_read(m_ir[20:16]);
            if (regwrite && wa != 5'd0) m_rf[wa] = wd;
            if (pcen) m_pc = npc;
            if (irwrite) m_ir = readdata;
            m_data = readdata;
            m_a = ra;
            m_b = rb;
            m_alo = res;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
        chk("adr", adr, iord ? m_alo : m_pc);
        chk("writedata", writedata, m_b);
        chk("op", {26'd0, op}, {26'd0, m_ir[31:26]});
        chk("funct", {26'd0, funct}, {26'd0, m_ir[5:0]});
        chk("zero", {31'd0, zero}, (ref_result() == 32'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        clk_edge();
    endtask

    task automatic idle();
        pcen = 1'b0; irwrite = 1'b0; regwrite = 1'b0; alusrca = 1'b0; iord = 1'b0;
        memtoreg = 1'b0; regdst = 1'b0; alusrcb = 2'd0; pcsrc = 2'd0;
        alucontrol = 3'd0; readdata = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] word);
        idle(); readdata = word; irwrite = 1'b1; pcen = 1'b1;
        alusrcb = 2'd1; alucontrol = 3'd2; cycle();
    endtask

    task automatic addi_rest();
        idle(); alusrcb = 2'd3; alucontrol = 3'd2; cycle();
        idle(); alusrca = 1'b1; alusrcb = 2'd2; alucontrol = 3'd2; cycle();
        idle(); regwrite = 1'b1; cycle();
    endtask

    initial begin
        model_reset();
        idle();
        reset = 1'b1;
        pcen = 1'b1;
        settle();
        chk("rst_adr", adr, 32'd0);
        chk("rst_op", {26'd0, op}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        clk_edge();
        settle();
        chk("rst_pc_hold", adr, 32'd0);
        reset = 1'b0;

        fetch(32'h2002_0005);
        idle(); settle();
        chk("fetch_op", {26'd0, op}, 32'h0000_0008);
        chk("fetch_pc", adr, 32'h0000_0004);
        addi_rest();
        idle(); cycle();
        idle(); settle();
        chk("addi_rf2", writedata, 32'd5);

        fetch(32'h2003_0007);
        addi_rest();
        fetch(32'h1063_0005);
        idle(); alusrcb = 2'd3; alucontrol = 3'd2; cycle();
        idle(); alusrca = 1'b1; alucontrol = 3'd6; pcsrc = 2'd1; pcen = 1'b1;
        settle();
        chk("beq_zero", {31'd0, zero}, 32'd1);
        clk_edge();
        idle(); settle();
        chk("beq_pc", adr, 32'h0000_0020);

        fetch(32'h00A5_2800);
        idle(); readdata = 32'h1000_0004; cycle();
        idle(); regwrite = 1'b1; memtoreg = 1'b1; cycle();
        idle(); cycle();
        idle(); alusrca = 1'b1; pcen = 1'b1; cycle();
        idle(); settle();
        chk("pc_preload", adr, 32'h1000_0004);
        idle(); irwrite = 1'b1; readdata = 32'h0800_0010; cycle();
        idle(); pcsrc = 2'd2; pcen = 1'b1; cycle();
        idle(); settle();
        chk("jump_pc", adr, 32'h1000_0040);

        idle(); readdata = 32'hFFFF_FFFF; cycle();
        idle(); regwrite = 1'b1; memtoreg = 1'b1; cycle();
        idle(); cycle();
        idle(); settle();
        chk("rf0_zero", writedata, 32'd0);

        fetch(32'h00C7_3000);
        idle(); readdata = 32'h8000_0000; cycle();
        idle(); regwrite = 1'b1; memtoreg = 1'b1; regdst = 1'b1; readdata = 32'd1; cycle();
        idle(); regwrite = 1'b1; memtoreg = 1'b1; cycle();
        idle(); cycle();
        idle(); alusrca = 1'b1; alucontrol = 3'd7; settle();
        chk("slt_zero", {31'd0, zero}, 32'd0);
        clk_edge();
        idle(); iord = 1'b1; settle();
        chk("slt_result", adr, 32'd1);

        for (int n = 0; n < 250; n++) begin
            pcen = 1'($urandom); irwrite = 1'($urandom); regwrite = 1'($urandom);
            alusrca = 1'($urandom); iord = 1'($urandom); memtoreg = 1'($urandom);
            regdst = 1'($urandom); alusrcb = 2'($urandom); pcsrc = 2'($urandom);
            alucontrol = 3'($urandom); readdata = $urandom;
            cycle();
        end

        idle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_adr", adr, 32'd0);
        chk("midrst_op", {26'd0, op}, 32'd0);
        chk("midrst_funct", {26'd0, funct}, 32'd0);
        chk("midrst_wd", writedata, 32'd0);
        pcen = 1'b1; regwrite = 1'b1; irwrite = 1'b1; readdata = 32'hDEAD_BEEF;
        clk_edge();
        reset = 1'b0;
        idle(); settle();
        chk("restart_adr", adr, 32'd0);
        fetch(32'h2004_0009);
        idle(); settle();
        chk("restart_pc", adr, 32'd4);

        for (int n = 0; n < 100; n++) begin
            pcen = 1'($urandom); irwrite = 1'($urandom); regwrite = 1'($urandom);
            alusrca = 1'($urandom); iord = 1'($urandom); memtoreg = 1'($urandom);
            regdst = 1'($urandom); alusrcb = 2'($urandom); pcsrc = 2'($urandom);
            alucontrol = 3'($urandom); readdata = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
